// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end for the pipelined core.
// A PC generator drives imem and pushes {pc, instruction} pairs into a
// DEPTH-entry prefetch FIFO. ID pops the head, so imem fetch keeps going
// while ID is stalled. A taken branch flushes the FIFO and redirects the PC.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   pc_out       fetch address to imem
//   inst_in      imem read data for pc_out (combinational read)
//   fetch_en     allow new fetches
//   br_taken     redirect from ID; br_target is the new PC
//   deq          ID consumes the head entry this cycle
//   inst_out     head instruction
//   inst_pc      PC of the head instruction
//   inst_valid   FIFO not empty
//   count        FIFO occupancy
//   full         count == DEPTH
module fetch_queue #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        pc_out,
    input  logic [INST_W-1:0]        inst_in,
    input  logic                     fetch_en,
    input  logic                     br_taken,
    input  logic [ADDR_W-1:0]        br_target,
    input  logic                     deq,
    output logic [INST_W-1:0]        inst_out,
    output logic [ADDR_W-1:0]        inst_pc,
    output logic                     inst_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
    logic [INST_W-1:0] mem_inst_q [DEPTH];

    logic deq_ok;
    logic fetch_ok;

    assign inst_valid = (count_q != '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;
    assign pc_out     = pc_q;
    assign inst_out   = mem_inst_q[rd_ptr_q];
    assign inst_pc    = mem_pc_q[rd_ptr_q];

    // A full FIFO still takes a fetch when the head leaves in the same cycle.
    assign deq_ok   = deq & inst_valid;
    assign fetch_ok = fetch_en & ~br_taken & (~full | deq_ok);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (br_taken) begin
            // Redirect wins over everything: drop all in-flight entries.
            pc_d     = br_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch_ok) begin
                pc_d     = pc_q + ADDR_W'(PC_INC);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (fetch_ok && !deq_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq_ok && !fetch_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; inst_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (fetch_ok) begin
            mem_pc_q[wr_ptr_q]   <= pc_q;
            mem_inst_q[wr_ptr_q] <= inst_in;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] inst_in;
    logic        fetch_en;
    logic        br_taken;
    logic [31:0] br_target;
    logic        deq;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic [2:0]  count;
    logic        full;

    // Second instance exercising PC wrap from a high reset vector.
    logic [31:0] w_pc_out;
    logic [31:0] w_inst_out;
    logic [31:0] w_inst_pc;
    logic        w_inst_valid;
    logic [2:0]  w_count;
    logic        w_full;
    logic [31:0] w_inst_in;
    logic        w_fetch_en;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_deq;

    int checks;
    int errors;

    fetch_queue u_dut (
        .clk        (clk),
        .reset      (reset),
        .pc_out     (pc_out),
        .inst_in    (inst_in),
        .fetch_en   (fetch_en),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .deq        (deq),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .count      (count),
        .full       (full)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk        (clk),
        .reset      (reset),
        .pc_out     (w_pc_out),
        .inst_in    (w_inst_in),
        .fetch_en   (w_fetch_en),
        .br_taken   (w_br_taken),
        .br_target  (w_br_target),
        .deq        (w_deq),
        .inst_out   (w_inst_out),
        .inst_pc    (w_inst_pc),
        .inst_valid (w_inst_valid),
        .count      (w_count),
        .full       (w_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fe;
        logic        br;
        logic [31:0] tgt;
        logic        dq;
        logic [2:0]  e_count;
        logic        e_valid;
        logic        e_full;
        logic [31:0] e_pc;
        logic [31:0] e_head;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one edge; sample #1 later and answer imem for the new pc_out.
    task automatic tick();
        @(posedge clk);
        #1;
        inst_in = pc_out ^ KEY;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] c, input logic v,
                             input logic f, input logic [31:0] pc, input logic [31:0] head);
        chk({tag, " count"}, 32'(count), 32'(c));
        chk({tag, " valid"}, 32'(inst_valid), 32'(v));
        chk({tag, " full"}, 32'(full), 32'(f));
        chk({tag, " pc_out"}, pc_out, pc);
        if (v) begin
            chk({tag, " inst_pc"}, inst_pc, head);
            chk({tag, " inst_out"}, inst_out, head ^ KEY);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        fetch_en    = 1'b0;
        br_taken    = 1'b0;
        br_target   = '0;
        deq         = 1'b0;
        inst_in     = '0;
        w_inst_in   = 32'h1234_5678;
        w_fetch_en  = 1'b1;
        w_br_taken  = 1'b0;
        w_br_target = '0;
        w_deq       = 1'b1;

        //          fe    br    tgt          dq    cnt   vld   full  pc_out        head
        // fill to full, then hold
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 3'd1, 1'b1, 1'b0, 32'h04,  32'h00};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 3'd2, 1'b1, 1'b0, 32'h08,  32'h00};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 3'd3, 1'b1, 1'b0, 32'h0C,  32'h00};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 3'd4, 1'b1, 1'b1, 32'h10,  32'h00};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 3'd4, 1'b1, 1'b1, 32'h10,  32'h00};
        // pass-through at full, pointers wrap
        vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 3'd4, 1'b1, 1'b1, 32'h14,  32'h04};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 3'd4, 1'b1, 1'b1, 32'h18,  32'h08};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 3'd4, 1'b1, 1'b1, 32'h1C,  32'h0C};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 3'd4, 1'b1, 1'b1, 32'h20,  32'h10};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 3'd4, 1'b1, 1'b1, 32'h24,  32'h14};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 3'd4, 1'b1, 1'b1, 32'h28,  32'h18};
        // branch while full with deq and fetch_en asserted
        vecs[11] = '{1'b1, 1'b1, 32'h100, 1'b1, 3'd0, 1'b0, 1'b0, 32'h100, 32'h00};
        vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b0, 3'd1, 1'b1, 1'b0, 32'h104, 32'h100};
        // back-to-back branches, last wins
        vecs[13] = '{1'b1, 1'b1, 32'h200, 1'b0, 3'd0, 1'b0, 1'b0, 32'h200, 32'h00};
        vecs[14] = '{1'b1, 1'b1, 32'h300, 1'b1, 3'd0, 1'b0, 1'b0, 32'h300, 32'h00};
        // deq on empty with fetch disabled is ignored
        vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 3'd0, 1'b0, 1'b0, 32'h300, 32'h00};
        vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 3'd0, 1'b0, 1'b0, 32'h300, 32'h00};
        vecs[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 3'd1, 1'b1, 1'b0, 32'h304, 32'h300};
        // steady stream: one per cycle, count stays 1
        vecs[18] = '{1'b1, 1'b0, 32'h0,   1'b1, 3'd1, 1'b1, 1'b0, 32'h308, 32'h304};
        vecs[19] = '{1'b1, 1'b0, 32'h0,   1'b1, 3'd1, 1'b1, 1'b0, 32'h30C, 32'h308};
        // fetch disabled: hold, then drain
        vecs[20] = '{1'b0, 1'b0, 32'h0,   1'b0, 3'd1, 1'b1, 1'b0, 32'h30C, 32'h308};
        vecs[21] = '{1'b0, 1'b0, 32'h0,   1'b1, 3'd0, 1'b0, 1'b0, 32'h30C, 32'h00};

        tick();
        chk_state("reset", 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            fetch_en  = vecs[i].fe;
            br_taken  = vecs[i].br;
            br_target = vecs[i].tgt;
            deq       = vecs[i].dq;
            tick();
            chk_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_valid,
                      vecs[i].e_full, vecs[i].e_pc, vecs[i].e_head);
        end

        // Reset mid-fill together with a branch: reset wins.
        fetch_en = 1'b1;
        br_taken = 1'b0;
        deq      = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk_state("midfill", 3'd3, 1'b1, 1'b0, 32'h318, 32'h30C);
        reset     = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h500;
        tick();
        chk_state("rst_br", 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset    = 1'b0;
        br_taken = 1'b0;
        fetch_en = 1'b0;
        chk("wrap pc0", w_pc_out, 32'hFFFF_FFF8);
        tick();
        chk("wrap pc1", w_pc_out, 32'hFFFF_FFFC);
        chk("wrap head", w_inst_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap pc2", w_pc_out, 32'h0000_0000);
        tick();
        chk("wrap pc3", w_pc_out, 32'h0000_0004);
        chk("wrap count", 32'(w_count), 32'd1);
        chk("idle pc", pc_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
